// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared state type, defaults and truth-table lookup for the gate response checker
package gate_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ERR_W_DEF = 8;
  function automatic logic expected_out(input logic [15:0] truth, input logic [3:0] vec);
    return truth[vec];
  endfunction
endpackage

// File: rtl/gate_chk_cov.sv
// gate_chk_cov: input-combination coverage bitmap with look-ahead completion flag
module gate_chk_cov #(
  parameter int N_IN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              set_en,
  input  logic [N_IN-1:0]   idx,
  output logic [2**N_IN-1:0] cov,
  output logic              all_covered
);
  localparam int NV = 2**N_IN;
  logic [NV-1:0] cov_nxt;
  // all_covered looks at the post-sample bitmap so the FSM can finish on the same edge
  always_comb cov_nxt = clear ? '0 : (cov | (set_en ? NV'(1) << idx : '0));
  assign all_covered = &cov_nxt;
  always_ff @(posedge clk) cov <= rst ? '0 : cov_nxt;
endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks gate DUT samples against a truth table; GATE_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int                  N_IN  = 2,
  parameter logic [2**N_IN-1:0]  TRUTH = 4'b1110,
  parameter int                  ERR_W = ERR_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                valid_i,
  input  logic [N_IN-1:0]     in_vec_i,
  input  logic                out_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ERR_W-1:0]    err_cnt_o,
  output logic [2**N_IN-1:0]  cov_o,
  output logic                first_fail_valid_o,
  output logic [N_IN-1:0]     first_fail_vec_o
);
  state_t state;
  logic [ERR_W-1:0] err_nxt;
  logic accept, mismatch, all_cov, finish;
  assign accept   = valid_i && state == RUN && !start_i;
  assign mismatch = accept && (out_i != expected_out(16'(TRUTH), 4'(in_vec_i)));
  assign err_nxt  = (mismatch && err_cnt_o != '1) ? err_cnt_o + 1'b1 : err_cnt_o;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign finish = all_cov || stop_i || mismatch;
`else
  assign finish = all_cov || stop_i;
`endif
  assign ready_o = state == RUN;
  assign busy_o  = state == RUN;
  assign done_o  = state == DONE;
  gate_chk_cov #(.N_IN(N_IN)) u_cov (
    .clk(clk_i),
    .rst(rst_i),
    .clear(start_i),
    .set_en(accept),
    .idx(in_vec_i),
    .cov(cov_o),
    .all_covered(all_cov)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      state              <= rst_i ? IDLE : RUN;
      err_cnt_o          <= '0;
      first_fail_valid_o <= 1'b0;
      first_fail_vec_o   <= '0;
      pass_o             <= 1'b0;
    end else if (state == RUN) begin
      err_cnt_o <= err_nxt;
      if (mismatch && !first_fail_valid_o) begin
        first_fail_valid_o <= 1'b1;
        first_fail_vec_o   <= in_vec_i;
      end
      if (finish) begin
        state  <= DONE;
        pass_o <= all_cov && err_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: scoreboard bench for gate_resp_checker (Or truth table, ERR_W=2)
module tb_gate_resp_checker;
  logic clk, rst, start, stop, valid, dout;
  logic [1:0] in_vec;
  logic ready, busy, done, pass, ffv;
  logic [1:0] err_cnt, ffvec;
  logic [3:0] cov;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic rdy, busy, done, pass;
    logic [1:0] err;
    logic [3:0] cov;
    logic ffv;
    logic [1:0] ffvec;
  } obs_t;
  obs_t sb[$];
  obs_t e;
  logic [3:0] truth = 4'b1110;
  int m_state = 0;
  logic [1:0] m_err = 0, m_ffvec = 0;
  logic [3:0] m_cov = 0;
  logic m_ffv = 0, m_pass = 0;

  gate_resp_checker #(.N_IN(2), .TRUTH(4'b1110), .ERR_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .valid_i(valid),
    .in_vec_i(in_vec), .out_i(dout), .ready_o(ready), .busy_o(busy), .done_o(done),
    .pass_o(pass), .err_cnt_o(err_cnt), .cov_o(cov),
    .first_fail_valid_o(ffv), .first_fail_vec_o(ffvec)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, st, sp, v, input logic [1:0] vec, input logic o);
    logic fail;
    rst = r; start = st; stop = sp; valid = v; in_vec = vec; dout = o;
    @(posedge clk);
    fail = 0;
    if (r) begin
      m_state = 0; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0; m_pass = 0;
    end else if (st) begin
      m_state = 1; m_err = 0; m_cov = 0; m_ffv = 0; m_ffvec = 0; m_pass = 0;
    end else if (m_state == 1) begin
      if (v) begin
        if (o !== truth[vec]) begin
          fail = 1;
          if (m_err != 2'd3) m_err++;
          if (!m_ffv) begin m_ffv = 1; m_ffvec = vec; end
        end
        m_cov[vec] = 1'b1;
      end
`ifndef GATE_CHK_STOP_ON_FAIL_EN
      fail = 0;
`endif
      if (m_cov == 4'hF || sp || fail) begin
        m_state = 2;
        m_pass = m_cov == 4'hF && m_err == 0;
      end
    end
    sb.push_back('{m_state == 1, m_state == 1, m_state == 2, m_pass, m_err, m_cov, m_ffv, m_ffvec});
    @(negedge clk);
    rst = 0; start = 0; stop = 0; valid = 0; in_vec = 0; dout = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ready", ready, e.rdy);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("pass", pass, e.pass);
      chk("err_cnt", err_cnt, e.err);
      chk("cov", cov, e.cov);
      chk("ff_valid", ffv, e.ffv);
      chk("ff_vec", ffvec, e.ffvec);
    end
  end

  initial begin
    logic [1:0] rv;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2'b11, 1);
    chk("rst_outputs", {ready, busy, done, pass, err_cnt, cov, ffv, ffvec}, 0);
    // Or pass
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 0); chk("or_cov0", cov, 4'b0001);
    step(0, 0, 0, 1, 2'b01, 1); chk("or_cov1", cov, 4'b0011);
    step(0, 0, 0, 1, 2'b10, 1); chk("or_cov2", cov, 4'b0111);
    step(0, 0, 0, 1, 2'b11, 1);
    chk("or_done", done, 1); chk("or_pass", pass, 1); chk("or_err", err_cnt, 0);
    // mismatches
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 1, 2'b10, 1);
    step(0, 0, 0, 1, 2'b11, 0);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("mm_err", err_cnt, 1);
`else
    chk("mm_err", err_cnt, 2);
`endif
    chk("mm_ffvec", ffvec, 2'b01); chk("mm_done", done, 1); chk("mm_pass", pass, 0);
    // early stop
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 0);
    step(0, 0, 0, 1, 2'b11, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("es_done", done, 1); chk("es_pass", pass, 0); chk("es_cov", cov, 4'b1001); chk("es_err", err_cnt, 0);
    // saturation
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'b00, 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("sat_err", err_cnt, 1); chk("sat_done", done, 1);
`else
    chk("sat_err", err_cnt, 3); chk("sat_busy", busy, 1);
`endif
    chk("sat_cov", cov, 4'b0001);
    // collisions
    step(0, 1, 0, 1, 2'b00, 0);
    chk("col_start_cov", cov, 0); chk("col_start_busy", busy, 1);
    step(0, 0, 1, 1, 2'b11, 1);
    chk("col_stop_cov", cov, 4'b1000); chk("col_stop_done", done, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("col_startstop_busy", busy, 1);
    step(0, 0, 0, 1, 2'b00, 1);
    step(1, 0, 0, 1, 2'b01, 1);
    chk("col_rst", {ready, busy, done, pass, err_cnt, cov, ffv, ffvec}, 0);
    step(0, 0, 1, 1, 2'b01, 1);
    chk("idle_ignore", {busy, done, cov}, 0);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 1);
    chk("sof_done", done, 1); chk("sof_ffvec", ffvec, 2'b00); chk("sof_ffv", ffv, 1);
    step(0, 0, 0, 1, 2'b01, 0);
    chk("sof_err", err_cnt, 1);
`endif
    // random traffic against the model
    for (int i = 0; i < 120; i++) begin
      rv = 2'($urandom_range(0, 3));
      step(0, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
           rv, ($urandom_range(0, 4) == 0) ? ~truth[rv] : truth[rv]);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
